retospect_bitstream_loader: RTL

// Upstream feeder of the neurochip configuration chain (clockbox + CNB array).

---
 rtl/retospect_bitstream_loader.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/retospect_bitstream_loader.sv
// rtl/retospect_bitstream_loader.sv - serializes config bytes onto the chain and repacks returned bits
module retospect_bitstream_loader #(
  parameter int CHAIN_LEN = 1488,
  parameter int CNT_W     = 11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  input  logic       rd_ready,
  output logic       config_en,
  output logic       bs_in,
  input  logic       bs_out,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

  localparam logic [CNT_W-1:0] LEN = CNT_W'(CHAIN_LEN);

  state_t           state;
  logic [7:0]       sr;
  logic [3:0]       sr_n;
  logic [CNT_W-1:0] bits_sent;
  logic [7:0]       rd_sr;
  logic [3:0]       rd_n;

  logic [CNT_W-1:0] remaining;
  logic [3:0]       take;
  logic [3:0]       eff;
  logic [3:0]       nxt_n;
  logic             cap_full;
  logic             rd_hold;
  logic             stall;
  logic             issue;
  logic             accept;
  logic [7:0]       rd_sr_cap;

  assign in_ready  = (state == LOAD) && (sr_n == 4'd0) && (bits_sent < LEN);
  assign accept    = in_valid && in_ready;
  assign busy      = (state != IDLE);
  assign remaining = LEN - bits_sent;
  assign take      = (remaining >= CNT_W'(8)) ? 4'd8 : remaining[3:0];

  // The bit on the chain wire this edge lands in rd_sr now; eff counts it.
  assign eff      = rd_n + {3'b000, config_en};
  assign cap_full = (eff == 4'd8);
  assign nxt_n    = cap_full ? 4'd0 : eff;
  assign rd_hold  = rd_valid && !rd_ready;

  // A bit issued now is captured next edge; if it would finish a byte while
  // rd_data is still occupied at that edge, hold it back.
  assign stall = rd_hold || ((nxt_n == 4'd7) && (cap_full || rd_hold));
  assign issue = (state == LOAD) && (sr_n != 4'd0) && !stall;

  always_comb begin
    rd_sr_cap = rd_sr;
    if (config_en) rd_sr_cap[rd_n[2:0]] = bs_out;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sr        <= 8'd0;
      sr_n      <= 4'd0;
      bits_sent <= '0;
      rd_sr     <= 8'd0;
      rd_n      <= 4'd0;
      rd_data   <= 8'd0;
      rd_valid  <= 1'b0;
      config_en <= 1'b0;
      bs_in     <= 1'b0;
      done      <= 1'b0;
    end else if (abort) begin
      state     <= IDLE;
      sr_n      <= 4'd0;
      bits_sent <= '0;
      rd_sr     <= 8'd0;
      rd_n      <= 4'd0;
      rd_valid  <= 1'b0;
      config_en <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;

      if (cap_full) begin
        rd_data  <= rd_sr_cap;
        rd_valid <= 1'b1;
        rd_n     <= 4'd0;
        rd_sr    <= 8'd0;
      end else begin
        rd_n  <= eff;
        rd_sr <= rd_sr_cap;
        if (rd_valid && rd_ready) rd_valid <= 1'b0;
      end

      config_en <= issue;
      if (issue) begin
        bs_in     <= sr[0];
        sr        <= {1'b0, sr[7:1]};
        sr_n      <= sr_n - 4'd1;
        bits_sent <= bits_sent + CNT_W'(1);
      end

      case (state)
        IDLE: begin
          if (start) begin
            state     <= LOAD;
            bits_sent <= '0;
            sr_n      <= 4'd0;
            rd_n      <= 4'd0;
            rd_sr     <= 8'd0;
          end
        end
        LOAD: begin
          if (accept) begin
            sr   <= in_data;
            sr_n <= take;
          end
          if ((bits_sent == LEN) && (sr_n == 4'd0)) state <= DRAIN;
        end
        DRAIN: begin
          // Leftover bits go out zero-padded as the last readback byte.
          if ((rd_n != 4'd0) && (!rd_valid || rd_ready)) begin
            rd_data  <= rd_sr;
            rd_valid <= 1'b1;
            rd_n     <= 4'd0;
            rd_sr    <= 8'd0;
          end else if ((rd_n == 4'd0) && rd_valid && rd_ready) begin
            done  <= 1'b1;
            state <= IDLE;
          end else if ((rd_n == 4'd0) && !rd_valid) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
